// File: rtl/clut_wr_if.sv
// Palette-write handshake between the bus side and clut_writer.
interface clut_wr_if #(
  parameter int CIDXW = 4,
  parameter int COLRW = 12
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CIDXW-1:0] wr_addr;
  logic [COLRW-1:0] wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/clut_writer.sv
// Buffers palette writes in a FIFO and commits them to the CLUT write port
// only during vertical blanking, so the palette never changes mid-frame.
module clut_writer #(
  parameter int CIDXW = 4,
  parameter int COLRW = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk_25MHz,
  input  logic                     btn_rst_n,
  clut_wr_if.slave                 wr,
  input  logic                     vblank,
  output logic                     clut_we,
  output logic [CIDXW-1:0]         clut_addr,
  output logic [COLRW-1:0]         clut_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drain_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [CIDXW-1:0] addr;
    logic [COLRW-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            push, pop, last;

  // Ready depends only on registered level, never on a same-cycle pop.
  assign wr.wr_ready = (level != LW'(DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;

  always_ff @(posedge clk_25MHz) begin
    if (!btn_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop && !last)  state_d = DRAIN;
      DRAIN: if (!pop || last)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // The first pop happens on the same edge that leaves IDLE, giving the
  // 2-edge push-to-write latency when vblank is already high.
  always_comb begin
    pop  = 1'b0;
    last = 1'b0;
    case (state_q)
      IDLE, DRAIN: pop = vblank && (level != '0);
      default:     pop = 1'b0;
    endcase
    last = pop && (level == LW'(1)) && !push;
  end

  always_ff @(posedge clk_25MHz) begin
    if (push) mem[wr_ptr] <= '{addr: wr.wr_addr, data: wr.wr_data};
  end

  always_ff @(posedge clk_25MHz) begin
    if (!btn_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      clut_we    <= 1'b0;
      clut_addr  <= '0;
      clut_data  <= '0;
      drain_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      clut_we    <= pop;
      drain_done <= last;
      if (pop) begin
        clut_addr <= mem[rd_ptr].addr;
        clut_data <= mem[rd_ptr].data;
      end
    end
  end
endmodule

// File: tb/tb_clut_writer.sv
// Random and directed stimulus against a queue-based reference of the palette FIFO.
module tb_clut_writer;
  localparam int CIDXW = 4;
  localparam int COLRW = 12;
  localparam int DEPTH = 16;

  typedef struct {
    logic [CIDXW-1:0] a;
    logic [COLRW-1:0] d;
  } ent_t;

  logic clk_25MHz = 1'b0;
  logic btn_rst_n;
  logic vblank;
  logic clut_we, drain_done;
  logic [CIDXW-1:0] clut_addr;
  logic [COLRW-1:0] clut_data;
  logic [$clog2(DEPTH):0] level;

  clut_wr_if #(.CIDXW(CIDXW), .COLRW(COLRW)) wr ();

  clut_writer #(.CIDXW(CIDXW), .COLRW(COLRW), .DEPTH(DEPTH)) dut (
    .clk_25MHz (clk_25MHz),
    .btn_rst_n (btn_rst_n),
    .wr        (wr),
    .vblank    (vblank),
    .clut_we   (clut_we),
    .clut_addr (clut_addr),
    .clut_data (clut_data),
    .level     (level),
    .drain_done(drain_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Reference: contents of the FIFO, and writes the CLUT port still owes.
  ent_t mq[$];
  ent_t exp_q[$];
  logic exp_we = 1'b0, exp_done = 1'b0;
  logic [CIDXW-1:0] exp_addr = '0;
  logic [COLRW-1:0] exp_data = '0;
  bit   mon_en = 1'b0;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_25MHz);
    if (!btn_rst_n) begin
      mq.delete();
      exp_q.delete();
      exp_we = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
    end else begin
      bit p_pop, p_push;
      ent_t e;
      p_pop  = vblank && (mq.size() != 0);
      p_push = wr.wr_valid && (mq.size() != DEPTH);
      exp_we = p_pop;
      exp_done = 0;
      if (p_pop) begin
        e = mq.pop_front();
        exp_q.push_back(e);
        exp_addr = e.a;
        exp_data = e.d;
        exp_done = (mq.size() == 0) && !p_push;
      end
      if (p_push) mq.push_back('{a: wr.wr_addr, d: wr.wr_data});
    end
  end

  initial forever begin
    @(negedge clk_25MHz);
    if (mon_en) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("wr_ready", 32'(wr.wr_ready), 32'(mq.size() != DEPTH));
      chk("clut_we", 32'(clut_we), 32'(exp_we));
      chk("drain_done", 32'(drain_done), 32'(exp_done));
      chk("clut_addr_hold", 32'(clut_addr), 32'(exp_addr));
      chk("clut_data_hold", 32'(clut_data), 32'(exp_data));
      if (clut_we) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_write: got addr %0h data %0h expected no write", clut_addr, clut_data);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("order_addr", 32'(clut_addr), 32'(e.a));
          chk("order_data", 32'(clut_data), 32'(e.d));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_25MHz); #1; end
  endtask

  task automatic push(input logic [CIDXW-1:0] a, input logic [COLRW-1:0] d);
    wr.wr_valid = 1'b1; wr.wr_addr = a; wr.wr_data = d;
    step(1);
    wr.wr_valid = 1'b0;
  endtask

  initial begin
    btn_rst_n = 1'b0; vblank = 1'b0;
    wr.wr_valid = 1'b1; wr.wr_addr = 4'h1; wr.wr_data = 12'h123;
    @(posedge clk_25MHz); #1;
    mon_en = 1'b1;
    step(1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_we", 32'(clut_we), 32'd0);
    btn_rst_n = 1'b1;
    step(1);                       // first push accepted right after release
    wr.wr_valid = 1'b0;
    vblank = 1'b1; step(2); vblank = 1'b0;

    // queue while active, then drain
    push(4'd3, 12'hF00); push(4'd7, 12'h0F0); push(4'd3, 12'h00F);
    step(2);
    vblank = 1'b1; step(4); vblank = 1'b0; step(1);

    // full FIFO, held 17th write, 1-cycle vblank
    for (int i = 0; i < DEPTH; i++) push(CIDXW'(i), COLRW'($urandom));
    wr.wr_valid = 1'b1; wr.wr_addr = 4'h9; wr.wr_data = 12'hABC;
    step(3);
    vblank = 1'b1; step(1); vblank = 1'b0;
    step(1);
    wr.wr_valid = 1'b0;
    step(2);
    vblank = 1'b1; step(DEPTH + 3); vblank = 1'b0;

    // partial drain
    for (int i = 0; i < 5; i++) push(CIDXW'($urandom), COLRW'($urandom));
    vblank = 1'b1; step(2); vblank = 1'b0; step(3);
    vblank = 1'b1; step(5); vblank = 1'b0;

    // concurrent push/pop
    vblank = 1'b1;
    for (int i = 0; i < 10; i++) push(CIDXW'($urandom), COLRW'($urandom));
    step(3); vblank = 1'b0;

    // reset mid-drain
    for (int i = 0; i < 8; i++) push(CIDXW'(i), COLRW'($urandom));
    vblank = 1'b1; step(3);
    btn_rst_n = 1'b0; step(1); btn_rst_n = 1'b1;
    step(10); vblank = 1'b0; step(2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      wr.wr_valid = ($urandom_range(0, 1) == 1);
      wr.wr_addr  = CIDXW'($urandom);
      wr.wr_data  = COLRW'($urandom);
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      btn_rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    wr.wr_valid = 1'b0; btn_rst_n = 1'b1;
    vblank = 1'b1; step(DEPTH + 4); vblank = 1'b0;
    step(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clut_writer.md
# clut_writer

Write-side front end for the colour lookup table (CLUT) that the VGA bit generator reads every pixel. It accepts palette writes from the CPU/bus side through a valid/ready handshake and buffers them in a FIFO. It commits them to the CLUT write port only while the display is in vertical blanking, so palette changes never tear mid-frame. It drives the `we`/`addr_write`/`data_in` inputs of the CLUT memory, which the bit generator currently ties off.

## Interface
- `CIDXW`, 4: colour index width in bits (CLUT address).
- `COLRW`, 12: colour width in bits (three 4-bit channels, R in the MSBs).
- `DEPTH`, 16: FIFO depth in entries. Must be a power of two and ≥2.
- `clk_25MHz`  in  1  pixel clock. Single clock domain for the whole block.
- `btn_rst_n`  in  1  reset: synchronous, active-low.
- `wr_valid`  in  1  producer presents a palette write.
- `wr_ready`  out  1  block can accept a write this cycle.
- `wr_addr`  in  CIDXW  CLUT index to write.
- `wr_data`  in  COLRW  colour value.
- `vblank`  in  1  high during vertical blanking. Must rise/fall ≥1 cycle before active video resumes.
- `clut_we`  out  1  CLUT write enable (registered).
- `clut_addr`  out  CIDXW  CLUT write address (registered).
- `clut_data`  out  COLRW  CLUT write data (registered).
- `level`  out  $clog2(DEPTH)+1  number of entries currently held.
- `drain_done`  out  1  one-cycle pulse: the last queued entry was written.

## Operation
- The FIFO holds {addr, data} pairs in a circular buffer with read/write pointers and a level counter.
- Push: the handshake completes on an edge where `wr_valid && wr_ready`. `wr_ready = (level != DEPTH)` and depends only on registered state, not on `wr_valid` or on a pop in the same cycle.
- State machine:
  - IDLE: go to DRAIN when `vblank && level != 0`.
  - DRAIN: pop one entry per cycle while `vblank && level != 0`.
  - DRAIN → IDLE: when `vblank` is sampled low, or when the pop empties the FIFO.
  - An undrained remainder waits for the next vblank. Order is strictly preserved.
- Pop: on the edge where the pop condition is sampled true, the head entry is registered onto `clut_addr`/`clut_data` and `clut_we` is set to 1. On every other edge `clut_we` is 0. `clut_addr`/`clut_data` hold their last value.
- Level update:
  - Push only: level +1.
  - Pop only: level −1.
  - Push and pop on the same edge: level unchanged.
  - Level never exceeds DEPTH and never underflows.
- Empty FIFO with a simultaneous push: the new entry is not popped on that edge. It is eligible from the next cycle.
- Full FIFO with a simultaneous pop: the push is refused (`wr_ready` was 0).
- `drain_done` is 1 on the same edge `clut_we` goes 1 for a pop that leaves level = 0, i.e. no push on that edge. Otherwise it is 0.
- Duplicate addresses are written in order; last write wins in the CLUT.
- Reset (`btn_rst_n` low at an edge, including mid-drain):
  - Pointers, level and state are cleared to IDLE.
  - `clut_we`=0, `clut_addr`=0, `clut_data`=0, `drain_done`=0.
  - Queued entries are discarded.
  - `wr_ready`=1 from the first cycle after reset.

## Timing
- Reset values: `wr_ready`=1, `level`=0, `clut_we`=0, `clut_addr`=0, `clut_data`=0, `drain_done`=0.
- Latency from push to CLUT write:
  - Minimum 2 edges when `vblank` is already high: the push edge, then the pop edge.
  - Otherwise the write waits for the first vblank cycle, then takes 1 edge.
- Throughput: 1 write/cycle in both directions.
- A pop sampled in the last vblank cycle produces `clut_we` 1 cycle later. The `vblank` lead requirement guarantees this still lands in blanking.
- Capacity per vblank: one entry per blanking cycle. Vblank at 640×480 (45 lines × 800 = 36000 cycles) far exceeds DEPTH.

## Test plan
- Reset: hold `btn_rst_n`=0 for 2 cycles with `wr_valid`=1 → `level`=0, `clut_we`=0, `drain_done`=0. After release, `wr_ready`=1 and the first push is accepted.
- Queue while active: `vblank`=0, push (3,'hF00), (7,'h0F0), (3,'h00F) → no `clut_we`, `level`=3. Raise `vblank` → `clut_we` high on 3 consecutive cycles with addr 3,7,3 and data 'hF00,'h0F0,'h00F. `drain_done` pulses with the third write; `level`=0.
- Full: `vblank`=0, push 16 entries → `level`=16, `wr_ready`=0, and a held 17th `wr_valid` is not accepted. Pulse `vblank` for 1 cycle → exactly one write (first entry), `wr_ready`=1 next cycle, and the 17th is accepted.
- Partial drain: 5 entries queued, `vblank` high for exactly 2 cycles → 2 writes, `level`=3, no `drain_done`. At the next vblank the remaining 3 are written in order, then `drain_done` pulses.
- Concurrent push/pop: `vblank`=1 with continuous pushes at 1/cycle → `level` stays constant (1 after the first), writes stream in order, no `drain_done` until pushes stop.
- Reset mid-drain: 8 queued, assert reset after 3 writes → `clut_we`=0 from the next cycle, `level`=0, no further writes at later vblanks.
